// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: drains a byte queue into the UART TXD register using only idle peripheral-bus cycles.
// CPU accesses always win the bus; the scheduler polls CON[4] and writes TXD only when the UART is idle.
module uart_tx_scheduler #(
    parameter int          DEPTH    = 16,
    parameter logic [31:0] CON_ADDR = 32'h4000_0020,
    parameter logic [31:0] TXD_ADDR = 32'h4000_0018
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cpu_rd,
    input  logic                       cpu_wr,
    input  logic [31:0]                cpu_addr,
    input  logic [31:0]                cpu_wdata,
    output logic [31:0]                cpu_rdata,
    output logic                       p_rd,
    output logic                       p_wr,
    output logic [31:0]                p_addr,
    output logic [31:0]                p_wdata,
    input  logic [31:0]                p_rdata,
    input  logic                       q_valid,
    input  logic [7:0]                 q_data,
    output logic                       q_ready,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic                       busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, POLL, SEND, HOLD} state_t;

    state_t        state, state_nxt;
    logic [1:0]    hold_cnt, hold_nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic          cpu_act, grant, push, pop;
    logic          s_rd, s_wr;
    logic [31:0]   s_addr, s_wdata;

    assign cpu_act   = cpu_rd | cpu_wr;
    assign grant     = !cpu_act;
    assign q_ready   = count != (AW+1)'(DEPTH);
    assign push      = q_valid && q_ready;
    assign pop       = state == SEND && grant;
    assign q_count   = count;
    assign busy      = count != '0 || state != IDLE;
    assign cpu_rdata = cpu_rd ? p_rdata : '0;
    assign p_rd      = cpu_act ? cpu_rd : s_rd;
    assign p_wr      = cpu_act ? cpu_wr : s_wr;
    assign p_addr    = cpu_act ? cpu_addr : s_addr;
    assign p_wdata   = cpu_act ? cpu_wdata : s_wdata;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end

    // Storage needs no reset: only entries between rp and wp are ever read.
    always_ff @(posedge clk)
        if (push) mem[wp] <= q_data;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: if (count != '0) state_nxt = POLL;
            POLL: if (grant && !p_rdata[4]) state_nxt = SEND;
            SEND: if (grant) begin
                state_nxt = HOLD;
                hold_nxt  = 2'd2;
            end
            HOLD: begin
                hold_nxt = hold_cnt - 2'd1;
                if (hold_cnt == 2'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_rd    = state == POLL;
        s_wr    = state == SEND;
        s_addr  = s_rd ? CON_ADDR : s_wr ? TXD_ADDR : '0;
        s_wdata = s_wr ? {24'b0, mem[rp]} : '0;
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: vector table for single-byte send and CPU pass-through, plus directed
// sequences for busy polling, CPU priority, full queue, push at full during pop, and async reset.
module tb_uart_tx_scheduler;
    localparam logic [31:0] CON = 32'h4000_0020;
    localparam logic [31:0] TXD = 32'h4000_0018;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        p_rd, p_wr;
    logic [31:0] p_addr, p_wdata, p_rdata;
    logic        q_valid, q_ready, busy;
    logic [7:0]  q_data;
    logic [4:0]  q_count;
    logic        uart_busy;
    logic [7:0]  sent_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic        crd;
        logic        cwr;
        logic [31:0] caddr;
        logic [31:0] cwd;
        logic        qv;
        logic [7:0]  qd;
        logic        ub;
        logic        erd;
        logic        ewr;
        logic [31:0] eaddr;
        logic [31:0] ewd;
        logic [31:0] erdata;
        logic [4:0]  ecnt;
        logic        ebusy;
        logic        eready;
    } vec_t;

    vec_t vt[11];

    uart_tx_scheduler dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata),
        .q_valid(q_valid), .q_data(q_data), .q_ready(q_ready), .q_count(q_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // UART model: CON reads return only bit 4 = busy; idle returns noise in all other bits.
    assign p_rdata = (p_rd && p_addr == CON) ? (uart_busy ? 32'h0000_0010 : 32'hFFFF_FFEF) : 32'h0;

    always @(negedge clk)
        if (reset && p_wr && !cpu_rd && !cpu_wr) sent_q.push_back(p_wdata[7:0]);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        q_valid = 1'b0; q_data = '0; uart_busy = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sent_q.delete();
        step;
    endtask

    initial begin
        int act;
        int rdok;
        int wrs;
        vt[0]  = '{'0, '0, '0, '0, '1, 8'h41, '0,  '0, '0, '0,  '0,        '0,           5'd0, '0, '1};
        vt[1]  = '{'0, '0, '0, '0, '0, 8'h00, '0,  '0, '0, '0,  '0,        '0,           5'd1, '1, '1};
        vt[2]  = '{'0, '0, '0, '0, '0, 8'h00, '0,  '1, '0, CON, '0,        '0,           5'd1, '1, '1};
        vt[3]  = '{'0, '0, '0, '0, '0, 8'h00, '0,  '0, '1, TXD, 32'h41,    '0,           5'd1, '1, '1};
        vt[4]  = '{'0, '0, '0, '0, '0, 8'h00, '0,  '0, '0, '0,  '0,        '0,           5'd0, '1, '1};
        vt[5]  = '{'0, '0, '0, '0, '0, 8'h00, '0,  '0, '0, '0,  '0,        '0,           5'd0, '1, '1};
        vt[6]  = '{'0, '0, '0, '0, '0, 8'h00, '0,  '0, '0, '0,  '0,        '0,           5'd0, '0, '1};
        vt[7]  = '{'1, '0, CON, '0, '0, 8'h00, '1, '1, '0, CON, '0,        32'h10,       5'd0, '0, '1};
        vt[8]  = '{'1, '0, CON, '0, '0, 8'h00, '0, '1, '0, CON, '0,        32'hFFFFFFEF, 5'd0, '0, '1};
        vt[9]  = '{'0, '1, 32'h1234, 32'hDEADBEEF, '0, 8'h00, '0,
                   '0, '1, 32'h1234, 32'hDEADBEEF, '0, 5'd0, '0, '1};
        vt[10] = '{'1, '0, TXD, '0, '0, 8'h00, '0, '1, '0, TXD, '0,        '0,           5'd0, '0, '1};

        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        q_valid = 1'b0; q_data = '0; uart_busy = 1'b0;
        #2;
        chk("rst.q_count", 32'(q_count), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.q_ready", 32'(q_ready), 32'd1);
        chk("rst.p_rd", 32'(p_rd), 32'd0);
        chk("rst.p_wr", 32'(p_wr), 32'd0);
        do_reset;

        for (int i = 0; i < 11; i++) begin
            cpu_rd = vt[i].crd; cpu_wr = vt[i].cwr; cpu_addr = vt[i].caddr; cpu_wdata = vt[i].cwd;
            q_valid = vt[i].qv; q_data = vt[i].qd; uart_busy = vt[i].ub;
            @(negedge clk);
            chk($sformatf("v%0d.p_rd", i), 32'(p_rd), 32'(vt[i].erd));
            chk($sformatf("v%0d.p_wr", i), 32'(p_wr), 32'(vt[i].ewr));
            chk($sformatf("v%0d.p_addr", i), p_addr, vt[i].eaddr);
            chk($sformatf("v%0d.p_wdata", i), p_wdata, vt[i].ewd);
            chk($sformatf("v%0d.cpu_rdata", i), cpu_rdata, vt[i].erdata);
            chk($sformatf("v%0d.q_count", i), 32'(q_count), 32'(vt[i].ecnt));
            chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vt[i].ebusy));
            chk($sformatf("v%0d.q_ready", i), 32'(q_ready), 32'(vt[i].eready));
            step;
        end

        // Busy wait: 50 polls with no write, then the write right after busy reads 0.
        do_reset;
        uart_busy = 1'b1; q_valid = 1'b1; q_data = 8'h55;
        step;
        q_valid = 1'b0;
        step;
        rdok = 0; wrs = 0;
        repeat (50) begin
            @(negedge clk);
            if (p_rd && p_addr == CON) rdok++;
            if (p_wr) wrs++;
            step;
        end
        chk("bw.polls", 32'(rdok), 32'd50);
        chk("bw.writes", 32'(wrs), 32'd0);
        uart_busy = 1'b0;
        @(negedge clk);
        chk("bw.last_poll", 32'(p_rd), 32'd1);
        step;
        @(negedge clk);
        chk("bw.p_wr", 32'(p_wr), 32'd1);
        chk("bw.p_addr", p_addr, TXD);
        chk("bw.p_wdata", p_wdata, 32'h55);
        step;

        // CPU priority over a pending SEND.
        do_reset;
        q_valid = 1'b1; q_data = 8'h77;
        step;
        q_valid = 1'b0;
        step;
        step;
        for (int k = 0; k < 5; k++) begin
            cpu_wr = 1'b1; cpu_addr = 32'h100 + 32'(k); cpu_wdata = 32'hA00 + 32'(k);
            @(negedge clk);
            chk($sformatf("cp%0d.p_wr", k), 32'(p_wr), 32'd1);
            chk($sformatf("cp%0d.p_addr", k), p_addr, 32'h100 + 32'(k));
            chk($sformatf("cp%0d.p_wdata", k), p_wdata, 32'hA00 + 32'(k));
            chk($sformatf("cp%0d.q_count", k), 32'(q_count), 32'd1);
            step;
        end
        cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        @(negedge clk);
        chk("cp.sched_wr", 32'(p_wr), 32'd1);
        chk("cp.sched_addr", p_addr, TXD);
        chk("cp.sched_wdata", p_wdata, 32'h77);
        chk("cp.count_before", 32'(q_count), 32'd1);
        step;
        @(negedge clk);
        chk("cp.count_after", 32'(q_count), 32'd0);
        chk("cp.idle_wr", 32'(p_wr), 32'd0);
        step;

        // Full queue: 17 pushes while UART busy, byte 0x10 dropped, 0x00..0x0F sent in order.
        do_reset;
        uart_busy = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            q_valid = 1'b1; q_data = 8'(i);
            @(negedge clk);
            chk($sformatf("fq%0d.q_count", i), 32'(q_count), 32'(i));
            chk($sformatf("fq%0d.q_ready", i), 32'(q_ready), (i < 16) ? 32'd1 : 32'd0);
            step;
        end
        q_valid = 1'b0;
        @(negedge clk);
        chk("fq.count_held", 32'(q_count), 32'd16);
        step;
        sent_q.delete();
        uart_busy = 1'b0;
        for (int k = 0; k < 200 && sent_q.size() < 16; k++) step;
        repeat (10) step;
        chk("fq.sent", 32'(sent_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < sent_q.size(); i++)
            chk($sformatf("fq.byte%0d", i), 32'(sent_q[i]), 32'(i));
        chk("fq.drained", 32'(q_count), 32'd0);

        // Push at count 16 coinciding with the granted SEND is refused; the next push is taken.
        do_reset;
        uart_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            q_valid = 1'b1; q_data = 8'(i);
            step;
        end
        q_valid = 1'b0;
        sent_q.delete();
        uart_busy = 1'b0;
        @(negedge clk);
        chk("pp.poll", 32'(p_rd), 32'd1);
        step;
        q_valid = 1'b1; q_data = 8'hA0;
        @(negedge clk);
        chk("pp.send", 32'(p_wr), 32'd1);
        chk("pp.q_ready_full", 32'(q_ready), 32'd0);
        step;
        q_data = 8'hA1;
        @(negedge clk);
        chk("pp.count15", 32'(q_count), 32'd15);
        chk("pp.q_ready", 32'(q_ready), 32'd1);
        step;
        q_valid = 1'b0;
        @(negedge clk);
        chk("pp.count16", 32'(q_count), 32'd16);
        step;
        for (int k = 0; k < 300 && sent_q.size() < 17; k++) step;
        repeat (10) step;
        chk("pp.sent", 32'(sent_q.size()), 32'd17);
        if (sent_q.size() == 17) begin
            chk("pp.first", 32'(sent_q[0]), 32'h00);
            chk("pp.byte15", 32'(sent_q[15]), 32'h0F);
            chk("pp.last", 32'(sent_q[16]), 32'hA1);
        end

        // Asynchronous reset during HOLD with 5 bytes queued.
        do_reset;
        uart_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            q_valid = 1'b1; q_data = 8'(i);
            step;
        end
        q_valid = 1'b0;
        uart_busy = 1'b0;
        step;
        q_valid = 1'b1; q_data = 8'h05;
        @(negedge clk);
        chk("rm.send", 32'(p_wr), 32'd1);
        chk("rm.send_byte", p_wdata, 32'h00);
        step;
        q_valid = 1'b0;
        @(negedge clk);
        chk("rm.hold_count", 32'(q_count), 32'd5);
        reset = 1'b0;
        #1;
        chk("rm.q_count", 32'(q_count), 32'd0);
        chk("rm.busy", 32'(busy), 32'd0);
        chk("rm.q_ready", 32'(q_ready), 32'd1);
        chk("rm.p_rd", 32'(p_rd), 32'd0);
        chk("rm.p_wr", 32'(p_wr), 32'd0);
        chk("rm.p_addr", p_addr, 32'd0);
        #2;
        reset = 1'b1;
        step;
        act = 0;
        repeat (10) begin
            @(negedge clk);
            if (p_rd || p_wr) act++;
            step;
        end
        chk("rm.quiet", 32'(act), 32'd0);
        q_valid = 1'b1; q_data = 8'hAA;
        step;
        q_valid = 1'b0;
        step;
        step;
        @(negedge clk);
        chk("rm.new_wr", 32'(p_wr), 32'd1);
        chk("rm.new_addr", p_addr, TXD);
        chk("rm.new_wdata", p_wdata, 32'hAA);
        step;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
